// File: rtl/sd_cmd_arbiter_if.sv
// Requester and command-master signals of sd_cmd_arbiter.
// The master modport is the arbiter side; slave is the surrounding logic.
interface sd_cmd_arbiter_if;
  logic        r0_req;
  logic        r1_req;
  logic [31:0] r0_arg;
  logic [31:0] r1_arg;
  logic [13:0] r0_cmd_set;
  logic [13:0] r1_cmd_set;
  logic        r0_rd;
  logic        r1_rd;
  logic        r0_wr;
  logic        r1_wr;
  logic        r0_done;
  logic        r1_done;
  logic [31:0] resp_o;
  logic [5:0]  err_o;
  logic        ok_o;
  logic        new_cmd_o;
  logic [31:0] arg_o;
  logic [13:0] cmd_set_o;
  logic        data_read_o;
  logic        data_write_o;
  logic        err_int_rst_o;
  logic        normal_int_rst_o;
  logic        busy_i;
  logic        cc_i;
  logic        ei_i;
  logic [4:0]  err_int_i;
  logic [31:0] resp_i;
  logic        card_present_i;

  modport master (
    input  r0_req, r1_req, r0_arg, r1_arg, r0_cmd_set, r1_cmd_set,
    input  r0_rd, r1_rd, r0_wr, r1_wr,
    input  busy_i, cc_i, ei_i, err_int_i, resp_i, card_present_i,
    output r0_done, r1_done, resp_o, err_o, ok_o, new_cmd_o, arg_o, cmd_set_o,
    output data_read_o, data_write_o, err_int_rst_o, normal_int_rst_o
  );

  modport slave (
    output r0_req, r1_req, r0_arg, r1_arg, r0_cmd_set, r1_cmd_set,
    output r0_rd, r1_rd, r0_wr, r1_wr,
    output busy_i, cc_i, ei_i, err_int_i, resp_i, card_present_i,
    input  r0_done, r1_done, resp_o, err_o, ok_o, new_cmd_o, arg_o, cmd_set_o,
    input  data_read_o, data_write_o, err_int_rst_o, normal_int_rst_o
  );
endinterface

// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter sharing one SD command master between two requesters,
// tracking each command to completion and enforcing a guard gap between commands.
module sd_cmd_arbiter #(
  parameter int unsigned GAP_CYCLES    = 8,
  parameter int unsigned ISSUE_TIMEOUT = 64
) (
  input logic               CLK_PAD_IO,
  input logic               RST_PAD_I,
  sd_cmd_arbiter_if.master  bus
);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitDone, StClear, StGap} state_e;

  localparam logic [15:0] IssueLast = 16'(ISSUE_TIMEOUT - 1);
  localparam logic [15:0] GapLast   = 16'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_grant_q, last_grant_d;
  logic        win;
  logic [15:0] cnt_q, cnt_d;
  logic        new_cmd_q, new_cmd_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        int_rst_q, int_rst_d;
  logic [31:0] resp_q, resp_d;
  logic [5:0]  err_q, err_d;
  logic        ok_q, ok_d;
  logic [31:0] arg_q, arg_d;
  logic [13:0] cmd_set_q, cmd_set_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;

  always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
    if (RST_PAD_I) begin
      state_q      <= StIdle;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 16'd0;
      new_cmd_q    <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      int_rst_q    <= 1'b0;
      resp_q       <= 32'd0;
      err_q        <= 6'd0;
      ok_q         <= 1'b0;
      arg_q        <= 32'd0;
      cmd_set_q    <= 14'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      new_cmd_q    <= new_cmd_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      int_rst_q    <= int_rst_d;
      resp_q       <= resp_d;
      err_q        <= err_d;
      ok_q         <= ok_d;
      arg_q        <= arg_d;
      cmd_set_q    <= cmd_set_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.r0_req || bus.r1_req) begin
          state_d = bus.card_present_i ? StIssue : StClear;
        end
      end
      StIssue: begin
        if (bus.busy_i) begin
          state_d = StWaitDone;
        end else if (cnt_q == IssueLast) begin
          state_d = StClear;
        end
      end
      StWaitDone: begin
        if (!bus.busy_i) begin
          state_d = StClear;
        end
      end
      StClear: state_d = StGap;
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    // On a tie the requester that did not win last time is served.
    win          = (bus.r0_req && bus.r1_req) ? ~last_grant_q : bus.r1_req;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    arg_d        = arg_q;
    cmd_set_d    = cmd_set_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    resp_d       = resp_q;
    err_d        = err_q;
    ok_d         = ok_q;
    cnt_d        = 16'd0;

    if (state_q == StIdle && state_d != StIdle) begin
      gnt_d     = win;
      arg_d     = win ? bus.r1_arg : bus.r0_arg;
      cmd_set_d = win ? bus.r1_cmd_set : bus.r0_cmd_set;
      rd_d      = win ? bus.r1_rd : bus.r0_rd;
      wr_d      = win ? bus.r1_wr : bus.r0_wr;
    end

    if ((state_q == StIssue || state_q == StGap) && state_d == state_q) begin
      cnt_d = cnt_q + 16'd1;
    end

    // Entering CLEAR from anywhere but WAIT_DONE means the command was aborted.
    if (state_q == StWaitDone && state_d == StClear) begin
      resp_d = bus.resp_i;
      err_d  = {1'b0, bus.err_int_i};
      ok_d   = bus.cc_i & ~bus.ei_i;
    end else if (state_d == StClear) begin
      err_d = 6'b100000;
      ok_d  = 1'b0;
    end

    if (state_q == StClear) begin
      last_grant_d = gnt_q;
    end

    new_cmd_d = (state_d == StIssue);
    int_rst_d = (state_d == StClear);
    done0_d   = int_rst_d & ~gnt_d;
    done1_d   = int_rst_d & gnt_d;
  end

  assign bus.new_cmd_o        = new_cmd_q;
  assign bus.r0_done          = done0_q;
  assign bus.r1_done          = done1_q;
  assign bus.err_int_rst_o    = int_rst_q;
  assign bus.normal_int_rst_o = int_rst_q;
  assign bus.resp_o           = resp_q;
  assign bus.err_o            = err_q;
  assign bus.ok_o             = ok_q;
  assign bus.arg_o            = arg_q;
  assign bus.cmd_set_o        = cmd_set_q;
  assign bus.data_read_o      = rd_q;
  assign bus.data_write_o     = wr_q;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Bench for sd_cmd_arbiter: command-master model, schedule-based reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_sd_cmd_arbiter;
  localparam int G = 8;
  localparam int T = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_cmd_arbiter_if bus();

  sd_cmd_arbiter #(.GAP_CYCLES(G), .ISSUE_TIMEOUT(T)) dut (
    .CLK_PAD_IO(clk),
    .RST_PAD_I (rst),
    .bus       (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Command master model: busy rises one edge after New_CMD is seen, lasts cfg_len clocks.
  logic        cfg_never = 1'b0;
  int          cfg_len = 20;
  logic        cfg_cc = 1'b1;
  logic        cfg_ei = 1'b0;
  logic [4:0]  cfg_err = 5'd0;
  logic [31:0] cfg_resp = 32'd0;
  logic        m_busy;
  int          m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy        <= 1'b0;
      m_cnt         <= 0;
      bus.cc_i      <= 1'b0;
      bus.ei_i      <= 1'b0;
      bus.err_int_i <= 5'd0;
      bus.resp_i    <= 32'd0;
    end else begin
      if (bus.normal_int_rst_o) begin
        bus.cc_i <= 1'b0;
        bus.ei_i <= 1'b0;
      end
      if (bus.err_int_rst_o) bus.err_int_i <= 5'd0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy        <= 1'b0;
          bus.cc_i      <= cfg_cc;
          bus.ei_i      <= cfg_ei;
          bus.err_int_i <= cfg_err;
          bus.resp_i    <= cfg_resp;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (bus.new_cmd_o && !cfg_never) begin
        m_busy <= 1'b1;
        m_cnt  <= cfg_len;
      end
    end
  end
  assign bus.busy_i = m_busy;

  // Reference model: at each grant, compute the command's timeline as cycle numbers.
  int          cyc, next_arb, new_lo, new_hi, done_cyc, m_win, m_last;
  logic        p_abort, p_ok, e_ok, e_rd, e_wr;
  logic [31:0] p_resp, e_resp, e_arg;
  logic [5:0]  p_err, e_err;
  logic [13:0] e_cmd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; next_arb = 1; new_lo = -1; new_hi = -2; done_cyc = -1;
      m_win = 0; m_last = 1; p_abort = 1'b0; p_ok = 1'b0; p_resp = 32'd0; p_err = 6'd0;
      e_ok = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_resp = 32'd0; e_arg = 32'd0;
      e_err = 6'd0; e_cmd = 14'd0;
    end else begin
      cyc = cyc + 1;
      if (cyc >= next_arb && (bus.r0_req || bus.r1_req)) begin
        if (bus.r0_req && bus.r1_req) m_win = 1 - m_last;
        else m_win = bus.r1_req ? 1 : 0;
        e_arg = m_win == 1 ? bus.r1_arg : bus.r0_arg;
        e_cmd = m_win == 1 ? bus.r1_cmd_set : bus.r0_cmd_set;
        e_rd  = m_win == 1 ? bus.r1_rd : bus.r0_rd;
        e_wr  = m_win == 1 ? bus.r1_wr : bus.r0_wr;
        if (!bus.card_present_i) begin
          new_lo = -1; new_hi = -2; done_cyc = cyc; p_abort = 1'b1;
        end else if (cfg_never) begin
          new_lo = cyc; new_hi = cyc + T - 1; done_cyc = cyc + T; p_abort = 1'b1;
        end else begin
          // New_CMD 2 clocks, busy cfg_len clocks, one clock to see busy low.
          new_lo = cyc; new_hi = cyc + 1; done_cyc = cyc + cfg_len + 2; p_abort = 1'b0;
          p_resp = cfg_resp; p_err = {1'b0, cfg_err}; p_ok = cfg_cc & ~cfg_ei;
        end
        next_arb = done_cyc + G + 2;
      end
      if (cyc == done_cyc) begin
        if (p_abort) begin
          e_err = 6'b100000; e_ok = 1'b0;
        end else begin
          e_resp = p_resp; e_err = p_err; e_ok = p_ok;
        end
        m_last = m_win;
      end
    end
  end

  // Per-cycle compare plus event trackers for the literal checks.
  int order[$];
  int nc_run = 0, nc_len_last = 0, pulse_run = 0, pulse_len_last = 0;
  int rises = 0, last_done_cyc = -1, done_at = -1, min_gap = 1000000;
  logic prev_nc = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      nc_run = 0; pulse_run = 0; prev_nc = 1'b0; last_done_cyc = -1;
    end else begin
      chk("new_cmd", {31'd0, bus.new_cmd_o}, {31'd0, (cyc >= new_lo && cyc <= new_hi)});
      chk("r0_done", {31'd0, bus.r0_done}, {31'd0, (cyc == done_cyc && m_win == 0)});
      chk("r1_done", {31'd0, bus.r1_done}, {31'd0, (cyc == done_cyc && m_win == 1)});
      chk("err_int_rst", {31'd0, bus.err_int_rst_o}, {31'd0, (cyc == done_cyc)});
      chk("normal_int_rst", {31'd0, bus.normal_int_rst_o}, {31'd0, (cyc == done_cyc)});
      chk("arg", bus.arg_o, e_arg);
      chk("cmd_set", {18'd0, bus.cmd_set_o}, {18'd0, e_cmd});
      chk("data_rd_wr", {30'd0, bus.data_read_o, bus.data_write_o}, {30'd0, e_rd, e_wr});
      chk("resp", bus.resp_o, e_resp);
      chk("err", {26'd0, bus.err_o}, {26'd0, e_err});
      chk("ok", {31'd0, bus.ok_o}, {31'd0, e_ok});

      if (bus.new_cmd_o) nc_run++;
      else if (nc_run != 0) begin nc_len_last = nc_run; nc_run = 0; end
      if (bus.new_cmd_o && !prev_nc) begin
        rises++;
        if (last_done_cyc >= 0 && cyc - last_done_cyc < min_gap) min_gap = cyc - last_done_cyc;
      end
      prev_nc = bus.new_cmd_o;
      if (bus.err_int_rst_o) pulse_run++;
      else if (pulse_run != 0) begin pulse_len_last = pulse_run; pulse_run = 0; end
      if (bus.r0_done) begin order.push_back(0); last_done_cyc = cyc; done_at = cyc; end
      if (bus.r1_done) begin order.push_back(1); last_done_cyc = cyc; done_at = cyc; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dones(input int n, input int budget, input string name);
    int target;
    int k;
    target = order.size() + n;
    k = 0;
    while (order.size() < target && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (order.size() < target) begin
      failures++;
      $display("FAIL %s_timeout: got %0d dones required %0d", name, order.size(), target);
    end
  endtask

  task automatic set_req(input int who, input logic [31:0] arg, input logic [13:0] cs,
                         input logic rd, input logic wr);
    if (who == 0) begin
      bus.r0_arg = arg; bus.r0_cmd_set = cs; bus.r0_rd = rd; bus.r0_wr = wr; bus.r0_req = 1'b1;
    end else begin
      bus.r1_arg = arg; bus.r1_cmd_set = cs; bus.r1_rd = rd; bus.r1_wr = wr; bus.r1_req = 1'b1;
    end
  endtask

  task automatic finish_cmd(input string name);
    wait_dones(1, 400, name);
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    repeat (G + 4) tick();
  endtask

  int base;
  int rises0;
  int req_cyc;
  int k;

  initial begin
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    bus.r0_arg = 32'd0; bus.r1_arg = 32'd0;
    bus.r0_cmd_set = 14'd0; bus.r1_cmd_set = 14'd0;
    bus.r0_rd = 1'b0; bus.r1_rd = 1'b0; bus.r0_wr = 1'b0; bus.r1_wr = 1'b0;
    bus.card_present_i = 1'b1;
    repeat (3) tick();
    chk("rst_new_cmd", {31'd0, bus.new_cmd_o}, 32'd0);
    chk("rst_done", {30'd0, bus.r0_done, bus.r1_done}, 32'd0);
    chk("rst_resp", bus.resp_o, 32'd0);
    chk("rst_err_ok", {25'd0, bus.err_o, bus.ok_o}, 32'd0);
    rst = 1'b0;
    tick();

    // r0 alone, normal completion.
    cfg_len = 20; cfg_cc = 1'b1; cfg_ei = 1'b0; cfg_err = 5'd0; cfg_resp = 32'h0000_01AA;
    set_req(0, 32'h0000_01AA, 14'h0819, 1'b0, 1'b0);
    finish_cmd("single");
    chk("single_newcmd_len", nc_len_last, 32'd2);
    chk("single_done_count", order.size(), 32'd1);
    chk("single_winner", order[0], 32'd0);
    chk("single_resp", bus.resp_o, 32'h0000_01AA);
    chk("single_ok", {31'd0, bus.ok_o}, 32'd1);
    chk("single_err", {26'd0, bus.err_o}, 32'd0);
    chk("single_pulse_len", pulse_len_last, 32'd1);

    // Continuous contention; r0 won last, so r1 goes first.
    cfg_len = 5; cfg_resp = 32'h0000_5555;
    min_gap = 1000000;
    base = order.size();
    set_req(0, 32'h0000_0A0A, 14'h1111, 1'b0, 1'b1);
    set_req(1, 32'h2222_2222, 14'h2A1A, 1'b1, 1'b0);
    wait_dones(4, 800, "contention");
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    repeat (G + 4) tick();
    chk("contention_count", order.size() - base, 32'd4);
    chk("contention_g0", order[base], 32'd1);
    chk("contention_g1", order[base + 1], 32'd0);
    chk("contention_g2", order[base + 2], 32'd1);
    chk("contention_g3", order[base + 3], 32'd0);
    chk("contention_gap", min_gap, G + 2);

    // Master never acknowledges.
    cfg_never = 1'b1;
    set_req(1, 32'h0000_7777, 14'h0D01, 1'b0, 1'b0);
    finish_cmd("timeout");
    chk("timeout_newcmd_len", nc_len_last, T);
    chk("timeout_winner", order[$], 32'd1);
    chk("timeout_err", {26'd0, bus.err_o}, 32'h20);
    chk("timeout_ok", {31'd0, bus.ok_o}, 32'd0);
    chk("timeout_resp_held", bus.resp_o, 32'h0000_5555);
    chk("timeout_new_cmd_low", {31'd0, bus.new_cmd_o}, 32'd0);

    // No card: aborted without issuing.
    cfg_never = 1'b0;
    bus.card_present_i = 1'b0;
    rises0 = rises;
    req_cyc = cyc;
    set_req(1, 32'h0000_3333, 14'h0200, 1'b0, 1'b0);
    finish_cmd("nocard");
    chk("nocard_latency", done_at - req_cyc + 1, 32'd2);
    chk("nocard_winner", order[$], 32'd1);
    chk("nocard_no_issue", rises - rises0, 32'd0);
    chk("nocard_err", {26'd0, bus.err_o}, 32'h20);
    bus.card_present_i = 1'b1;

    // Completion with an error interrupt.
    cfg_len = 7; cfg_cc = 1'b1; cfg_ei = 1'b1; cfg_err = 5'b00010; cfg_resp = 32'hDEAD_BEEF;
    set_req(0, 32'h1234_5678, 14'h1119, 1'b1, 1'b0);
    finish_cmd("ei");
    chk("ei_err", {26'd0, bus.err_o}, 32'h02);
    chk("ei_ok", {31'd0, bus.ok_o}, 32'd0);
    chk("ei_resp", bus.resp_o, 32'hDEAD_BEEF);

    // Reset during WAIT_DONE, then a tie must go to r0 again.
    cfg_len = 30; cfg_ei = 1'b0; cfg_err = 5'd0; cfg_resp = 32'h0000_0F0F;
    base = order.size();
    set_req(1, 32'h0BAD_F00D, 14'h3FFF, 1'b1, 1'b1);
    k = 0;
    while (!m_busy && k < 20) begin tick(); k++; end
    chk("rst_reach_busy", {31'd0, m_busy}, 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("midrst_new_cmd", {31'd0, bus.new_cmd_o}, 32'd0);
    chk("midrst_arg", bus.arg_o, 32'd0);
    chk("midrst_cmd_set", {18'd0, bus.cmd_set_o}, 32'd0);
    chk("midrst_rd_wr", {30'd0, bus.data_read_o, bus.data_write_o}, 32'd0);
    chk("midrst_resp", bus.resp_o, 32'd0);
    chk("midrst_err_ok", {25'd0, bus.err_o, bus.ok_o}, 32'd0);
    chk("midrst_pulses", {29'd0, bus.r0_done, bus.r1_done, bus.err_int_rst_o}, 32'd0);
    bus.r1_req = 1'b0;
    repeat (2) tick();
    chk("midrst_no_done", order.size() - base, 32'd0);
    rst = 1'b0;
    tick();
    cfg_len = 4;
    set_req(0, 32'h0000_0001, 14'h0101, 1'b0, 1'b0);
    set_req(1, 32'h0000_0002, 14'h0202, 1'b0, 1'b0);
    finish_cmd("post_rst");
    chk("post_rst_winner", order[$], 32'd0);
    chk("post_rst_resp", bus.resp_o, 32'h0000_0F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
